// File: rtl/systolic_operand_buf.sv
// systolic_operand_buf
// Double-banked operand buffer feeding one edge of the systolic MAC array. The host writes
// one LANES-wide vector per cycle into either bank. A start streams a whole bank out, either
// diagonally skewed (lane l delayed by l beats) or lane-aligned. While one bank streams, the
// other bank stays writable (ping-pong).
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset (memory contents are kept)
//   wr_en_i      write strobe
//   wr_bank_i    target bank of the write
//   wr_addr_i    vector index of the write
//   wr_data_i    vector to write, lane l at [l*BITS +: BITS]
//   start_i      stream request
//   rd_bank_i    bank to stream, sampled with an accepted start
//   skew_i       1 = skewed stream, 0 = aligned stream, sampled with an accepted start
//   out_data_o   streamed vector (registered), invalid lanes read as zero
//   out_valid_o  per-lane valid (registered)
//   busy_o       stream in progress, through the cycle showing the last beat
//   done_o       one-cycle pulse with the last beat
//   err_o        one-cycle pulse after a rejected start and/or rejected write
module systolic_operand_buf #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned LANES = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic                    wr_bank_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [LANES*BITS-1:0]   wr_data_i,
  input  logic                    start_i,
  input  logic                    rd_bank_i,
  input  logic                    skew_i,
  output logic [LANES*BITS-1:0]   out_data_o,
  output logic [LANES-1:0]        out_valid_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned LenSkew  = DEPTH + LANES - 1;
  localparam int unsigned LenAlign = DEPTH;
  localparam int unsigned TW       = $clog2(DEPTH + LANES);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                  state_q;
  logic [TW-1:0]           t_q;
  logic                    bank_q;
  logic                    skew_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic [LANES*BITS-1:0]   out_data_q;
  logic [LANES-1:0]        out_valid_q;

  logic [LANES*BITS-1:0]   mem_q [2][DEPTH];

  // Write acceptance: address in range, and not aimed at the bank currently being streamed.
  logic addr_ok;
  logic wr_reject;
  logic wr_commit;

  if (DEPTH < (1 << AW)) begin : g_sparse_addr
    assign addr_ok = 32'(wr_addr_i) < DEPTH;
  end else begin : g_dense_addr
    assign addr_ok = 1'b1;
  end

  assign wr_reject = !addr_ok || (busy_q && (wr_bank_i == bank_q));
  assign wr_commit = wr_en_i && !wr_reject;

  always_ff @(posedge clk_i) begin
    if (wr_commit) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  // Beat t: lane l reads vector k = t - off_l, where off_l = l when skewed.
  logic [LANES*BITS-1:0] beat_data;
  logic [LANES-1:0]      beat_valid;
  int unsigned           tt;
  int unsigned           off;
  int unsigned           k;
  logic                  last_beat;

  always_comb begin
    beat_data  = '0;
    beat_valid = '0;
    tt         = 32'(t_q);
    off        = 32'd0;
    k          = 32'd0;
    for (int unsigned l = 0; l < LANES; l++) begin
      off = skew_q ? l : 32'd0;
      if (tt >= off && (tt - off) < DEPTH) begin
        k = tt - off;
        beat_data[l*BITS +: BITS] = mem_q[bank_q][k[AW-1:0]][l*BITS +: BITS];
        beat_valid[l]             = 1'b1;
      end
    end
    last_beat = skew_q ? (tt == LenSkew - 1) : (tt == LenAlign - 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      t_q         <= '0;
      bank_q      <= 1'b0;
      skew_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      // A rejected start and a rejected write on the same edge give one pulse.
      err_q       <= (start_i && busy_q) || (wr_en_i && wr_reject);
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          // busy_q is still high in the done cycle, so a start there is rejected.
          if (start_i && !busy_q) begin
            state_q <= StStream;
            bank_q  <= rd_bank_i;
            skew_q  <= skew_i;
            t_q     <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        StStream: begin
          out_data_q  <= beat_data;
          out_valid_q <= beat_valid;
          t_q         <= t_q + TW'(1);
          if (last_beat) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
